// File: rtl/cam_dvp_capture_pkg.sv
// Shared types for the DVP capture block: FSM states, error bit positions, scale decode.
package cam_dvp_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        VSYNC,
        GAP,
        LINE
    } cap_state_t;

    localparam int ERR_WIDTH  = 0;
    localparam int ERR_HEIGHT = 1;
    localparam int ERR_SCALE  = 2;

    // Unsupported factors fall back to 1:1 (shift 0).
    function automatic logic [1:0] scale_shift(input logic [2:0] s);
        case (s)
            3'd2:    return 2'd1;
            3'd4:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic scale_ok(input logic [2:0] s);
        return (s == 3'd1) || (s == 3'd2) || (s == 3'd4);
    endfunction

endpackage

// File: rtl/cam_dvp_capture_if.sv
// DVP input side plus decimated pixel stream output side of the capture block.
interface cam_dvp_capture_if #(
    parameter int DATA_W = 8,
    parameter int DIM_W  = 16
);
    logic              en;
    logic [DIM_W-1:0]  cam_width;
    logic [DIM_W-1:0]  cam_height;
    logic [2:0]        cam_scale;
    logic              cam_vsync_i;
    logic              cam_href_i;
    logic [DATA_W-1:0] cam_data_i;
    logic [DATA_W-1:0] pixel_o;
    logic              pixel_en;
    logic              new_pic;
    logic              new_line;
    logic              frame_done;
    logic [DIM_W-1:0]  col_cnt;
    logic [DIM_W-1:0]  row_cnt;
    logic [2:0]        err;

    modport master (
        output en, cam_width, cam_height, cam_scale, cam_vsync_i, cam_href_i, cam_data_i,
        input  pixel_o, pixel_en, new_pic, new_line, frame_done, col_cnt, row_cnt, err
    );

    modport slave (
        input  en, cam_width, cam_height, cam_scale, cam_vsync_i, cam_href_i, cam_data_i,
        output pixel_o, pixel_en, new_pic, new_line, frame_done, col_cnt, row_cnt, err
    );
endinterface

// File: rtl/cam_dvp_capture_hscale.sv
// Horizontal box decimator: sums 1<<shift pixels and emits the truncated mean.
// One register stage from valid to pixel_en; abort drops any partial group.
module cam_dvp_capture_hscale #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    input  logic [1:0]        shift,
    input  logic              line_start,
    input  logic              abort,
    output logic [DATA_W-1:0] pixel,
    output logic              pixel_en
);
    logic [DATA_W+1:0] acc, acc_base, sum;
    logic [1:0]        cnt, cnt_base, last;

    // line_start arrives together with the first pixel, so it restarts the group in place.
    always_comb begin
        acc_base = line_start ? '0 : acc;
        cnt_base = line_start ? 2'd0 : cnt;
        sum      = acc_base + {2'b00, data};
        last     = 2'((3'd1 << shift) - 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            pixel    <= '0;
            pixel_en <= 1'b0;
        end else begin
            pixel_en <= 1'b0;
            if (abort) begin
                acc <= '0;
                cnt <= '0;
            end else if (valid) begin
                if (cnt_base == last) begin
                    pixel    <= DATA_W'(sum >> shift);
                    pixel_en <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt_base + 2'd1;
                end
            end else if (line_start) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/cam_dvp_capture.sv
// DVP frame capture: input register, edge detect, framing FSM, decimation, markers and sticky errors.
// pixel_en follows the completing input sample by two clocks; no backpressure, the sensor free-runs.
module cam_dvp_capture
    import cam_dvp_capture_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DIM_W     = 16,
    parameter int VSYNC_POL = 1
) (
    input  logic clk,
    input  logic rst,
    cam_dvp_capture_if.slave bus
);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    logic              vs_r, vs_p, hr_r, hr_p;
    logic [DATA_W-1:0] d_r;
    logic              vs_rise, vs_fall, hr_rise, hr_fall;

    cap_state_t        state, next_state;
    logic [DIM_W-1:0]  width_l, height_l, rows, in_cnt, cur_idx, col_cnt, row_cnt;
    logic [1:0]        shift_l, grp_last;
    logic [2:0]        err;
    logic              frame_done, latch, line_start, line_end, close;
    logic              row_keep, pix_valid, abort;
    logic [DATA_W-1:0] pix;
    logic              pix_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_r <= 1'b0;
            vs_p <= 1'b0;
            hr_r <= 1'b0;
            hr_p <= 1'b0;
            d_r  <= '0;
        end else begin
            vs_r <= bus.cam_vsync_i;
            vs_p <= vs_r;
            hr_r <= bus.cam_href_i;
            hr_p <= hr_r;
            d_r  <= bus.cam_data_i;
        end
    end

    assign vs_rise = (vs_r == VS_ACT) && (vs_p != VS_ACT);
    assign vs_fall = (vs_r != VS_ACT) && (vs_p == VS_ACT);
    assign hr_rise = hr_r && !hr_p;
    assign hr_fall = !hr_r && hr_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A vsync edge is checked first in GAP/LINE so it beats a coincident href edge.
    always_comb begin
        next_state = state;
        latch      = 1'b0;
        line_start = 1'b0;
        line_end   = 1'b0;
        close      = 1'b0;
        case (state)
            IDLE:  if (vs_rise && bus.en) next_state = VSYNC;
            VSYNC: if (vs_fall) begin
                       next_state = GAP;
                       latch      = 1'b1;
                   end
            GAP:   if (vs_rise) begin
                       next_state = VSYNC;
                       close      = 1'b1;
                   end else if (rows == height_l) begin
                       next_state = IDLE;
                       close      = 1'b1;
                   end else if (hr_rise) begin
                       next_state = LINE;
                       line_start = 1'b1;
                   end
            LINE:  if (vs_rise) begin
                       next_state = VSYNC;
                       close      = 1'b1;
                   end else if (hr_fall) begin
                       next_state = GAP;
                       line_end   = 1'b1;
                   end
            default: next_state = IDLE;
        endcase
    end

    assign grp_last  = 2'((3'd1 << shift_l) - 3'd1);
    assign row_keep  = (rows[1:0] & grp_last) == 2'b00;
    assign cur_idx   = line_start ? '0 : in_cnt;
    assign pix_valid = hr_r && (line_start || (state == LINE && !vs_rise))
                       && (cur_idx < width_l) && row_keep;
    assign abort     = line_end || (state == LINE && vs_rise) || latch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_l    <= '0;
            height_l   <= '0;
            shift_l    <= '0;
            err        <= '0;
            rows       <= '0;
            in_cnt     <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (latch) begin
                width_l  <= bus.cam_width;
                height_l <= bus.cam_height;
                shift_l  <= scale_shift(bus.cam_scale);
                err      <= {~scale_ok(bus.cam_scale), 2'b00};
                rows     <= '0;
                row_cnt  <= '0;
                in_cnt   <= '0;
            end
            if (line_start) begin
                in_cnt <= DIM_W'(1);
            end else if (state == LINE && hr_r && in_cnt < width_l) begin
                in_cnt <= in_cnt + DIM_W'(1);
            end
            if (line_end) begin
                rows <= rows + DIM_W'(1);
                if (row_keep) row_cnt <= row_cnt + DIM_W'(1);
                if (in_cnt < width_l) err[ERR_WIDTH] <= 1'b1;
            end
            if (close) begin
                frame_done <= 1'b1;
                if (rows < height_l) err[ERR_HEIGHT] <= 1'b1;
            end
            // col_cnt names the pixel currently on pixel_o, so it steps after each emit.
            if (line_start)  col_cnt <= '0;
            else if (pix_en) col_cnt <= col_cnt + DIM_W'(1);
        end
    end

    cam_dvp_capture_hscale #(.DATA_W(DATA_W)) u_hscale (
        .clk        (clk),
        .rst        (rst),
        .data       (d_r),
        .valid      (pix_valid),
        .shift      (shift_l),
        .line_start (line_start),
        .abort      (abort),
        .pixel      (pix),
        .pixel_en   (pix_en)
    );

    assign bus.pixel_o    = pix;
    assign bus.pixel_en   = pix_en;
    assign bus.new_line   = pix_en && (col_cnt == '0);
    assign bus.new_pic    = pix_en && (col_cnt == '0) && (row_cnt == '0);
    assign bus.frame_done = frame_done;
    assign bus.col_cnt    = col_cnt;
    assign bus.row_cnt    = row_cnt;
    assign bus.err        = err;
endmodule

// File: tb/tb_cam_dvp_capture.sv
// Directed bench for cam_dvp_capture: framing, decimation, markers, errors and reset.
module tb_cam_dvp_capture;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cam_dvp_capture_if #(.DATA_W(8), .DIM_W(16)) bus ();

    cam_dvp_capture #(.DATA_W(8), .DIM_W(16), .VSYNC_POL(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] q_pix[$];
    int         q_col[$];
    int         q_row[$];
    int         q_cyc[$];
    bit         q_nl[$];
    bit         q_np[$];
    logic [2:0] q_derr[$];
    int         grp_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pixel_en === 1'b1) begin
                q_pix.push_back(bus.pixel_o);
                q_col.push_back(int'(bus.col_cnt));
                q_row.push_back(int'(bus.row_cnt));
                q_cyc.push_back(cyc);
                q_nl.push_back(bus.new_line);
                q_np.push_back(bus.new_pic);
            end
            if (bus.frame_done === 1'b1) q_derr.push_back(bus.err);
        end
    end

    function automatic logic [7:0] pat(int mode, int line, int i, int width);
        case (mode)
            0:       return 8'(line * width + i);
            1:       return (i % 2 == 1) ? 8'd20 : 8'd10;
            2:       return 8'(4 * i);
            default: return (i % 2 == 1) ? 8'd21 : 8'd10;
        endcase
    endfunction

    task automatic vsync_pulse;
        @(negedge clk);
        bus.cam_vsync_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.cam_vsync_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_line(int len, int mode, int line, int width, int scale, bit keep);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            bus.cam_href_i = 1'b1;
            bus.cam_data_i = pat(mode, line, i, width);
            if (keep && (i % scale == scale - 1)) grp_cyc.push_back(cyc);
        end
        @(negedge clk);
        bus.cam_href_i = 1'b0;
        bus.cam_data_i = 8'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(int w, int h, int scale, int lines, int short_line, int short_len, int mode);
        bus.cam_width  = 16'(w);
        bus.cam_height = 16'(h);
        bus.cam_scale  = 3'(scale);
        vsync_pulse();
        for (int l = 0; l < lines; l++)
            send_line((l == short_line) ? short_len : w, mode, l, w, scale, (l % scale) == 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.cam_width = 16'd0;
        bus.cam_height = 16'd0;
        bus.cam_scale = 3'd1;
        bus.cam_vsync_i = 1'b0;
        bus.cam_href_i = 1'b0;
        bus.cam_data_i = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.pixel_en, bus.new_pic, bus.new_line, bus.frame_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.pixel_en, bus.new_pic, bus.new_line, bus.frame_done});
        end
        checks++;
        if (bus.pixel_o !== 8'd0 || bus.col_cnt !== 16'd0 || bus.row_cnt !== 16'd0 || bus.err !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: got pix=%0d col=%0d row=%0d err=%b expected all 0",
                     bus.pixel_o, bus.col_cnt, bus.row_cnt, bus.err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scale1;
        int b, d;
        b = q_pix.size();
        d = q_derr.size();
        send_frame(8, 4, 1, 4, -1, 0, 0);
        checks++;
        if (q_pix.size() - b != 32) begin
            errors++;
            $display("FAIL s1_count: got %0d expected 32", q_pix.size() - b);
        end
        for (int i = 0; i < 32 && b + i < q_pix.size(); i++) begin
            checks++;
            if (q_pix[b+i] !== 8'(i) || q_col[b+i] != i % 8 || q_row[b+i] != i / 8 ||
                q_nl[b+i] != (i % 8 == 0) || q_np[b+i] != (i == 0)) begin
                errors++;
                $display("FAIL s1_pix[%0d]: got pix=%0d col=%0d row=%0d nl=%0d np=%0d expected pix=%0d col=%0d row=%0d nl=%0d np=%0d",
                         i, q_pix[b+i], q_col[b+i], q_row[b+i], q_nl[b+i], q_np[b+i],
                         i, i % 8, i / 8, (i % 8 == 0), (i == 0));
            end
        end
        checks++;
        if (q_derr.size() - d != 1) begin
            errors++;
            $display("FAIL s1_done: got %0d frame_done pulses expected 1", q_derr.size() - d);
        end
        checks++;
        if (q_derr.size() > d && q_derr[d] !== 3'b000) begin
            errors++;
            $display("FAIL s1_err: got %b expected 000", q_derr[d]);
        end
    endtask

    task automatic test_scale2;
        int b;
        b = q_pix.size();
        send_frame(16, 8, 2, 8, -1, 0, 1);
        checks++;
        if (q_pix.size() - b != 32) begin
            errors++;
            $display("FAIL s2_count: got %0d expected 32", q_pix.size() - b);
        end
        for (int i = 0; i < 32 && b + i < q_pix.size(); i++) begin
            checks++;
            if (q_pix[b+i] !== 8'd15 || q_col[b+i] != i % 8 || q_row[b+i] != i / 8 ||
                q_nl[b+i] != (i % 8 == 0)) begin
                errors++;
                $display("FAIL s2_pix[%0d]: got pix=%0d col=%0d row=%0d nl=%0d expected pix=15 col=%0d row=%0d nl=%0d",
                         i, q_pix[b+i], q_col[b+i], q_row[b+i], q_nl[b+i], i % 8, i / 8, (i % 8 == 0));
            end
        end
    endtask

    task automatic test_scale4;
        int b, g;
        b = q_pix.size();
        g = grp_cyc.size();
        send_frame(16, 8, 4, 8, -1, 0, 2);
        checks++;
        if (q_pix.size() - b != 8 || grp_cyc.size() - g != 8) begin
            errors++;
            $display("FAIL s4_count: got %0d pixels %0d groups expected 8 and 8",
                     q_pix.size() - b, grp_cyc.size() - g);
        end
        for (int i = 0; i < 8 && b + i < q_pix.size() && g + i < grp_cyc.size(); i++) begin
            checks++;
            if (q_pix[b+i] !== 8'(16 * (i % 4) + 6) || q_col[b+i] != i % 4 || q_row[b+i] != i / 4) begin
                errors++;
                $display("FAIL s4_pix[%0d]: got pix=%0d col=%0d row=%0d expected pix=%0d col=%0d row=%0d",
                         i, q_pix[b+i], q_col[b+i], q_row[b+i], 16 * (i % 4) + 6, i % 4, i / 4);
            end
            checks++;
            if (q_cyc[b+i] - grp_cyc[g+i] != 2) begin
                errors++;
                $display("FAIL s4_latency[%0d]: got %0d clk expected 2", i, q_cyc[b+i] - grp_cyc[g+i]);
            end
        end
    endtask

    task automatic test_width;
        int b, d;
        b = q_pix.size();
        d = q_derr.size();
        send_frame(16, 8, 2, 8, 2, 10, 3);
        checks++;
        if (q_pix.size() - b != 29) begin
            errors++;
            $display("FAIL w_count: got %0d expected 29", q_pix.size() - b);
        end
        for (int i = 0; i < 29 && b + i < q_pix.size(); i++) begin
            int er, ec;
            er = (i < 8) ? 0 : (i < 13) ? 1 : (i < 21) ? 2 : 3;
            ec = (i < 8) ? i : (i < 13) ? i - 8 : (i < 21) ? i - 13 : i - 21;
            checks++;
            if (q_pix[b+i] !== 8'd15 || q_row[b+i] != er || q_col[b+i] != ec || q_nl[b+i] != (ec == 0)) begin
                errors++;
                $display("FAIL w_pix[%0d]: got pix=%0d col=%0d row=%0d nl=%0d expected pix=15 col=%0d row=%0d nl=%0d",
                         i, q_pix[b+i], q_col[b+i], q_row[b+i], q_nl[b+i], ec, er, (ec == 0));
            end
        end
        checks++;
        if (q_derr.size() - d != 1 || q_derr[q_derr.size()-1] !== 3'b001) begin
            errors++;
            $display("FAIL w_err: got %0d pulses last err=%b expected 1 pulse err=001",
                     q_derr.size() - d, q_derr[q_derr.size()-1]);
        end
        d = q_derr.size();
        send_frame(16, 8, 2, 8, -1, 0, 1);
        checks++;
        if (q_derr.size() - d != 1 || q_derr[q_derr.size()-1] !== 3'b000) begin
            errors++;
            $display("FAIL w_clear: got %0d pulses last err=%b expected 1 pulse err=000",
                     q_derr.size() - d, q_derr[q_derr.size()-1]);
        end
    endtask

    task automatic test_short_frame;
        int b, d;
        b = q_pix.size();
        d = q_derr.size();
        send_frame(8, 8, 1, 3, -1, 0, 0);
        send_frame(8, 4, 1, 4, -1, 0, 0);
        checks++;
        if (q_derr.size() - d != 2) begin
            errors++;
            $display("FAIL sf_done: got %0d pulses expected 2", q_derr.size() - d);
        end else begin
            checks++;
            if (q_derr[d] !== 3'b010 || q_derr[d+1] !== 3'b000) begin
                errors++;
                $display("FAIL sf_err: got %b then %b expected 010 then 000", q_derr[d], q_derr[d+1]);
            end
        end
        checks++;
        if (q_pix.size() - b != 56) begin
            errors++;
            $display("FAIL sf_count: got %0d expected 56", q_pix.size() - b);
        end else begin
            checks++;
            if (q_np[b+24] != 1'b1 || q_pix[b+24] !== 8'd0 || q_pix[b+55] !== 8'd31 || q_row[b+55] != 3) begin
                errors++;
                $display("FAIL sf_next: got np=%0d first=%0d last=%0d row=%0d expected np=1 first=0 last=31 row=3",
                         q_np[b+24], q_pix[b+24], q_pix[b+55], q_row[b+55]);
            end
        end
    endtask

    task automatic test_en0;
        int b, d;
        b = q_pix.size();
        d = q_derr.size();
        bus.en = 1'b0;
        send_frame(8, 4, 1, 4, -1, 0, 0);
        bus.en = 1'b1;
        checks++;
        if (q_pix.size() != b || q_derr.size() != d) begin
            errors++;
            $display("FAIL en0: got %0d pixels %0d done expected 0 and 0", q_pix.size() - b, q_derr.size() - d);
        end
    endtask

    task automatic test_reset_midline;
        bus.cam_width  = 16'd8;
        bus.cam_height = 16'd4;
        bus.cam_scale  = 3'd1;
        vsync_pulse();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.cam_href_i = 1'b1;
            bus.cam_data_i = 8'(7 + i);
        end
        checks++;
        if (bus.pixel_en !== 1'b1 || bus.pixel_o !== 8'd8) begin
            errors++;
            $display("FAIL rm_pre: got en=%b pix=%0d expected en=1 pix=8", bus.pixel_en, bus.pixel_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.pixel_en, bus.new_line, bus.new_pic, bus.frame_done} !== 4'b0000 ||
            bus.pixel_o !== 8'd0 || bus.col_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rm_clear: got en=%b pix=%0d col=%0d expected all 0",
                     bus.pixel_en, bus.pixel_o, bus.col_cnt);
        end
        @(negedge clk);
        bus.cam_href_i = 1'b0;
        bus.cam_data_i = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bad_scale;
        int b, d;
        b = q_pix.size();
        d = q_derr.size();
        send_frame(8, 4, 3, 4, -1, 0, 0);
        checks++;
        if (q_pix.size() - b != 32) begin
            errors++;
            $display("FAIL bs_count: got %0d expected 32", q_pix.size() - b);
        end else begin
            checks++;
            if (q_pix[b+13] !== 8'd13 || q_col[b+13] != 5 || q_row[b+13] != 1) begin
                errors++;
                $display("FAIL bs_pix: got pix=%0d col=%0d row=%0d expected 13 5 1",
                         q_pix[b+13], q_col[b+13], q_row[b+13]);
            end
        end
        checks++;
        if (q_derr.size() - d != 1 || q_derr[q_derr.size()-1] !== 3'b100) begin
            errors++;
            $display("FAIL bs_err: got %0d pulses last err=%b expected 1 pulse err=100",
                     q_derr.size() - d, q_derr[q_derr.size()-1]);
        end
    endtask

    initial begin
        test_reset();
        test_scale1();
        test_scale2();
        test_scale4();
        test_width();
        test_short_frame();
        test_en0();
        test_reset_midline();
        test_bad_scale();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
